// File: rtl/mem_sequencer.sv
// mem_sequencer: serialises instruction fetches and data loads/stores onto one
// asynchronous 16-bit SRAM, sequencing ce/oe/we with registered strobes.
module mem_sequencer #(
    parameter int ADDR_W      = 18,
    parameter int READ_CYCLES = 2,
    parameter int WE_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [15:0]       fetch_addr,
    output logic [15:0]       inst_rdata,
    output logic              inst_ack,
    input  logic [1:0]        mem_ctrl,
    input  logic [15:0]       data_addr,
    input  logic [15:0]       data_wdata,
    output logic [15:0]       data_rdata,
    output logic              data_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [15:0]       ram_din,
    output logic [15:0]       ram_dout,
    output logic              ram_dout_en,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);
    typedef enum logic [2:0] {IDLE, I_READ, D_READ, W_SETUP, W_PULSE, W_HOLD} state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       last_data_q;
    logic       data_v;
    logic       data_win;
    logic       fetch_win;

    assign data_v    = (mem_ctrl == 2'b01) || (mem_ctrl == 2'b10);
    // On contention, last_data_q hands the bus to whoever did not go last.
    assign data_win  = data_v && (!fetch_req || !last_data_q);
    assign fetch_win = fetch_req && !data_win;
    assign busy      = state_q != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_data_q <= 1'b0;
            ram_addr    <= '0;
            ram_dout    <= '0;
            ram_dout_en <= 1'b0;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            inst_rdata  <= '0;
            data_rdata  <= '0;
            inst_ack    <= 1'b0;
            data_ack    <= 1'b0;
        end else begin
            inst_ack <= 1'b0;
            data_ack <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_win) begin
                        last_data_q <= 1'b1;
                        ram_addr    <= ADDR_W'(data_addr);
                        ram_ce_n    <= 1'b0;
                        if (mem_ctrl == 2'b01) begin
                            state_q  <= D_READ;
                            ram_oe_n <= 1'b0;
                            cnt_q    <= 4'(READ_CYCLES - 1);
                        end else begin
                            state_q     <= W_SETUP;
                            ram_dout    <= data_wdata;
                            ram_dout_en <= 1'b1;
                        end
                    end else if (fetch_win) begin
                        last_data_q <= 1'b0;
                        ram_addr    <= ADDR_W'(fetch_addr);
                        ram_ce_n    <= 1'b0;
                        ram_oe_n    <= 1'b0;
                        cnt_q       <= 4'(READ_CYCLES - 1);
                        state_q     <= I_READ;
                    end
                end
                I_READ, D_READ: begin
                    if (cnt_q == 4'd0) begin
                        if (state_q == I_READ) begin
                            inst_rdata <= ram_din;
                            inst_ack   <= 1'b1;
                        end else begin
                            data_rdata <= ram_din;
                            data_ack   <= 1'b1;
                        end
                        ram_ce_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                W_SETUP: begin
                    ram_we_n <= 1'b0;
                    cnt_q    <= 4'(WE_CYCLES - 1);
                    state_q  <= W_PULSE;
                end
                W_PULSE: begin
                    if (cnt_q == 4'd0) begin
                        ram_we_n <= 1'b1;
                        state_q  <= W_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                W_HOLD: begin
                    data_ack    <= 1'b1;
                    ram_ce_n    <= 1'b1;
                    ram_dout_en <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: two instances (2/2 and 1/3 cycle timing) driven by directed and
// random request rounds, checked against an arbitration + memory-contents model.
module tb_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req   [2];
    logic [15:0] fetch_addr  [2];
    logic [15:0] inst_rdata  [2];
    logic        inst_ack    [2];
    logic [1:0]  mem_ctrl    [2];
    logic [15:0] data_addr   [2];
    logic [15:0] data_wdata  [2];
    logic [15:0] data_rdata  [2];
    logic        data_ack    [2];
    logic        busy        [2];
    logic [17:0] ram_addr    [2];
    logic [15:0] ram_din     [2];
    logic [15:0] ram_dout    [2];
    logic        ram_dout_en [2];
    logic        ram_ce_n    [2];
    logic        ram_oe_n    [2];
    logic        ram_we_n    [2];

    logic [15:0] emem     [2][1024];
    logic [15:0] exp_inst [2];
    logic [15:0] exp_data [2];
    bit          exp_last [2];
    int          n_total = 0;
    int          n_pass  = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(int a);
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    function automatic int rc(int k);
        return k == 0 ? 2 : 1;
    endfunction

    function automatic int wc(int k);
        return k == 0 ? 2 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : du
        logic [15:0] mem [1024];
        int          viol = 0;
        int          both = 0;
        mem_sequencer #(.ADDR_W(18), .READ_CYCLES(g == 0 ? 2 : 1), .WE_CYCLES(g == 0 ? 2 : 3)) u_dut (
            .clk(clk), .rst(rst),
            .fetch_req(fetch_req[g]), .fetch_addr(fetch_addr[g]),
            .inst_rdata(inst_rdata[g]), .inst_ack(inst_ack[g]),
            .mem_ctrl(mem_ctrl[g]), .data_addr(data_addr[g]), .data_wdata(data_wdata[g]),
            .data_rdata(data_rdata[g]), .data_ack(data_ack[g]), .busy(busy[g]),
            .ram_addr(ram_addr[g]), .ram_din(ram_din[g]), .ram_dout(ram_dout[g]),
            .ram_dout_en(ram_dout_en[g]), .ram_ce_n(ram_ce_n[g]),
            .ram_oe_n(ram_oe_n[g]), .ram_we_n(ram_we_n[g])
        );
        assign ram_din[g] = (!ram_ce_n[g] && !ram_oe_n[g]) ? mem[ram_addr[g][9:0]] : 16'h0;
        always @(posedge clk) begin
            if (rst) for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
            else if (!ram_ce_n[g] && !ram_we_n[g] && ram_dout_en[g]) mem[ram_addr[g][9:0]] = ram_dout[g];
        end
        always @(negedge clk) begin
            if (!ram_oe_n[g] && ram_dout_en[g]) viol++;
            if (inst_ack[g] && data_ack[g]) both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) emem[k][i] = init_val(i);
            exp_inst[k] = '0;
            exp_data[k] = '0;
            exp_last[k] = 1'b0;
            fetch_req[k] = 1'b0;
            mem_ctrl[k]  = 2'b00;
        end
    endtask

    // One request round; requests are applied just after an edge while the DUT is idle.
    task automatic run_round(input int k, input bit df, input logic [1:0] dt,
                             input logic [15:0] fa, input logic [15:0] da, input logic [15:0] wd);
        bit pend_f, pend_d, do_fetch, is_store;
        int n, oe_cnt, we_cnt, lat;
        fetch_req[k]  = df;
        fetch_addr[k] = fa;
        mem_ctrl[k]   = dt;
        data_addr[k]  = da;
        data_wdata[k] = wd;
        pend_f = df;
        pend_d = (dt == 2'b01) || (dt == 2'b10);
        if (!pend_f && !pend_d) begin
            repeat (4) begin
                step();
                check("no_grant", 32'({busy[k], inst_ack[k], data_ack[k]}), 32'd0);
            end
        end
        while (pend_f || pend_d) begin
            do_fetch    = pend_f && (!pend_d || exp_last[k]);
            is_store    = !do_fetch && dt == 2'b10;
            exp_last[k] = !do_fetch;
            n = 0; oe_cnt = 0; we_cnt = 0;
            do begin
                step();
                n++;
                if (n == 1 && do_fetch) fetch_addr[k] = ~fa;
                if (n == 1 && !do_fetch) begin
                    data_addr[k]  = ~da;
                    data_wdata[k] = ~wd;
                end
                if (!ram_oe_n[k]) oe_cnt++;
                if (!ram_we_n[k]) we_cnt++;
            end while (!inst_ack[k] && !data_ack[k] && n < 40);
            lat = is_store ? wc(k) + 3 : rc(k) + 1;
            check("latency", 32'(n), 32'(lat));
            check("inst_ack", 32'(inst_ack[k]), 32'(do_fetch));
            check("data_ack", 32'(data_ack[k]), 32'(!do_fetch));
            check("busy_at_ack", 32'(busy[k]), 32'd0);
            check("strobes_at_ack", 32'({ram_ce_n[k], ram_oe_n[k], ram_we_n[k], ram_dout_en[k]}), 32'hE);
            check("ram_addr", 32'(ram_addr[k]), 32'(do_fetch ? fa : da));
            check("oe_cycles", 32'(oe_cnt), 32'(is_store ? 0 : rc(k)));
            check("we_cycles", 32'(we_cnt), 32'(is_store ? wc(k) : 0));
            if (do_fetch) exp_inst[k] = emem[k][fa[9:0]];
            else if (!is_store) exp_data[k] = emem[k][da[9:0]];
            else begin
                emem[k][da[9:0]] = wd;
                check("ram_dout", 32'(ram_dout[k]), 32'(wd));
            end
            check("inst_rdata", 32'(inst_rdata[k]), 32'(exp_inst[k]));
            check("data_rdata", 32'(data_rdata[k]), 32'(exp_data[k]));
            if (do_fetch) begin
                fetch_req[k] = 1'b0;
                pend_f = 1'b0;
            end else begin
                mem_ctrl[k] = 2'b00;
                pend_d = 1'b0;
            end
        end
        step();
        check("idle_after", 32'({busy[k], inst_ack[k], data_ack[k]}), 32'd0);
        mem_ctrl[k] = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            fetch_addr[k] = '0; data_addr[k] = '0; data_wdata[k] = '0;
        end
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rst_busy_ack", 32'({busy[k], inst_ack[k], data_ack[k]}), 32'd0);
            check("rst_strobes", 32'({ram_ce_n[k], ram_oe_n[k], ram_we_n[k], ram_dout_en[k]}), 32'hE);
            check("rst_ram_addr", 32'(ram_addr[k]), 32'd0);
            check("rst_ram_dout", 32'(ram_dout[k]), 32'd0);
            check("rst_rdata", 32'({inst_rdata[k], data_rdata[k]}), 32'd0);
        end
        run_round(0, 1'b0, 2'b10, 16'h0000, 16'h0040, 16'h1234);
        run_round(0, 1'b1, 2'b00, 16'h0040, 16'h0000, 16'h0000);
        run_round(0, 1'b0, 2'b10, 16'h0000, 16'h8001, 16'hBEEF);
        run_round(0, 1'b0, 2'b01, 16'h0000, 16'h8001, 16'h0000);
        repeat (2) run_round(0, 1'b1, 2'b01, 16'h0040, 16'h8001, 16'h0000);
        run_round(0, 1'b0, 2'b11, 16'h0000, 16'h0123, 16'h5555);
        run_round(0, 1'b1, 2'b11, 16'h0040, 16'h0123, 16'h5555);
        mem_ctrl[0] = 2'b10; data_addr[0] = 16'h0200; data_wdata[0] = 16'hA5A5;
        step();
        step();
        check("we_low_pre_rst", 32'(ram_we_n[0]), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_strobes", 32'({ram_ce_n[0], ram_oe_n[0], ram_we_n[0], ram_dout_en[0]}), 32'hE);
        check("rst_async_busy", 32'(busy[0]), 32'd0);
        model_reset();
        repeat (3) begin
            step();
            check("rst_no_ack", 32'({inst_ack[0], data_ack[0]}), 32'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            repeat (200) begin
                bit          df;
                logic [1:0]  dt;
                df = 1'($urandom_range(0, 1));
                dt = 2'($urandom_range(0, 3));
                if (!df && dt == 2'b00) dt = 2'b01;
                run_round(k, df, dt, 16'($urandom_range(0, 15) * 16'h1041),
                          16'($urandom_range(0, 15) * 16'h1041), 16'($urandom));
            end
        end
        check("no_contention_0", 32'(du[0].viol), 32'd0);
        check("no_contention_1", 32'(du[1].viol), 32'd0);
        check("no_double_ack_0", 32'(du[0].both), 32'd0);
        check("no_double_ack_1", 32'(du[1].both), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Multi-cycle controller between the pipeline's memory ports and a single asynchronous 16-bit external SRAM. It serialises instruction fetches and data loads/stores onto the one shared SRAM bus. It generates the chip-enable, output-enable and write-enable sequencing, and returns read data with a one-cycle acknowledge pulse. `busy` tells the pipeline to hold its stages while an access is in flight.

## Interface
- `ADDR_W`, 18: SRAM address width. Must be ≥16; 16-bit request addresses are zero-extended.
- `READ_CYCLES`, 2: cycles the read strobes are held before data capture. Range 1–15.
- `WE_CYCLES`, 2: cycles `ram_we_n` is held low on a write. Range 1–15.

- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fetch_req` in 1: instruction fetch requested; level, held until `inst_ack`.
- `fetch_addr` in 16: fetch address; sampled when the fetch is accepted.
- `inst_rdata` out 16: last fetched instruction; held until the next fetch completes.
- `inst_ack` out 1: one-cycle pulse, `inst_rdata` updated this cycle.
- `mem_ctrl` in 2: data request. 00 = none, 01 = load, 10 = store, 11 = none. Level, held until `data_ack`.
- `data_addr` in 16: load/store address; sampled on accept.
- `data_wdata` in 16: store data; sampled on accept.
- `data_rdata` out 16: last load result; held until the next load completes.
- `data_ack` out 1: one-cycle pulse on load or store completion.
- `busy` out 1: high whenever state ≠ IDLE.
- `ram_addr` out ADDR_W: SRAM address.
- `ram_din` in 16: SRAM read data.
- `ram_dout` out 16: SRAM write data.
- `ram_dout_en` out 1: high = controller drives the SRAM data bus.
- `ram_ce_n`, `ram_oe_n`, `ram_we_n` out 1 each: active-low SRAM strobes.

## Operation
- **States:** IDLE, I_READ, D_READ, W_SETUP, W_PULSE, W_HOLD.
- **Arbitration in IDLE:**
  - Valid data request (01/10) with no fetch request: data wins.
  - Fetch request with no valid data request: fetch wins.
  - Both pending: the winner is set by the `last_data` flag. If `last_data`=1, fetch wins; otherwise data wins.
  - `last_data` is set on every data grant and cleared on every fetch grant.
- **On grant:** address (and store data) are latched into internal registers. Later input changes do not affect the access in flight.
- **I_READ / D_READ:**
  - Strobes: `ram_ce_n`=0, `ram_oe_n`=0, `ram_we_n`=1, `ram_dout_en`=0.
  - A counter runs READ_CYCLES cycles.
  - On the last cycle, `ram_din` is captured into `inst_rdata` or `data_rdata`, the matching ack is pulsed, and the state returns to IDLE.
- **W_SETUP:** 1 cycle. `ram_ce_n`=0, `ram_dout_en`=1, `ram_we_n`=1, `ram_oe_n`=1.
- **W_PULSE:** WE_CYCLES cycles with `ram_we_n`=0.
- **W_HOLD:** 1 cycle. `ram_we_n`=1, data still driven. `data_ack` pulses, then the state goes to IDLE.
- **Bus contention guard:** `ram_oe_n` and `ram_dout_en` are never both active.
- **Counter:** 4-bit; it reloads on every state entry.
- **Outside an access:** `ram_addr` and `ram_dout` hold their last values.

## Timing
- **Reset values:** state=IDLE, `last_data`=0, `ram_ce_n`/`ram_oe_n`/`ram_we_n`=1, `ram_dout_en`=0, `ram_addr`=0, `ram_dout`=0, `inst_rdata`=0, `data_rdata`=0, `inst_ack`=0, `data_ack`=0, `busy`=0.
- **Reset mid-access:** strobes deassert immediately (asynchronously). The access is abandoned with no ack.
- **Latency** (request seen in IDLE at edge N):
  - Read: ack asserted in the cycle after edge N+READ_CYCLES (N+2 at default).
  - Write: ack asserted in the cycle after edge N+WE_CYCLES+2 (N+4 at default).
- **Back-to-back:** one IDLE cycle always separates two accesses. At most one ack is high in any cycle.
- **Request withdrawal:** a request dropped before grant is ignored. A request dropped after grant does not abort the access.
- **Registered outputs:** all strobes are registered; no combinational path from inputs to `ram_*`.

## Test plan
- **Reset:** assert `rst` mid-W_PULSE.
  - Expect `ram_we_n`=1 and `ram_dout_en`=0 immediately, `busy`=0, no `data_ack`.
- **Single fetch:** `fetch_addr`=0x0040, SRAM model returns 0x1234.
  - Expect `ram_addr`=0x00040, `inst_rdata`=0x1234, `inst_ack` high for exactly 1 cycle, 2 cycles after grant.
- **Store then load:** store 0xBEEF to 0x8001, then load from 0x8001.
  - Expect `ram_we_n` low for exactly 2 cycles, `data_rdata`=0xBEEF, two separate `data_ack` pulses.
- **Simultaneous requests:** `fetch_req`=1 and `mem_ctrl`=01 held continuously.
  - Expect grants to alternate data, fetch, data, fetch.
  - Expect one IDLE cycle between each grant and no overlapping acks.
- **Bus contention:** checker over random traffic with READ_CYCLES=1 and WE_CYCLES=3.
  - Expect `ram_oe_n`=0 never together with `ram_dout_en`=1.
  - Expect `mem_ctrl`=11 never granted.
